// File: rtl/qpm_pkg.sv
// Shared types and sizing helpers for the QueryPatchMem sequencer.
package qpm_pkg;

  localparam int DATA_WIDTH_D = 11;
  localparam int PATCH_SIZE_D = 5;
  localparam int ADDR_WIDTH_D = 9;
  localparam int DEPTH_D      = 512;
  localparam int PATCH_W      = DATA_WIDTH_D * PATCH_SIZE_D;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_e;

  // Bits needed to hold any value from 0 to max_val inclusive.
  function automatic int count_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/patch_fifo2.sv
// Two-entry synchronous FIFO that decouples port 1 reads from downstream backpressure.
module patch_fifo2
  import qpm_pkg::*;
#(
  parameter int W = PATCH_W,
  localparam int CW = count_width(2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem_r [2];
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_ok_s;
  logic          push_ok_s;

  assign pop_ok_s  = pop && (count_r != CW'(0));
  assign push_ok_s = push && ((count_r != CW'(2)) || pop_ok_s);
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];

  // Entry storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= CW'(0);
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
    end
  end

endmodule

// File: rtl/query_patch_mem_ctrl.sv
// Load/stream sequencer for QueryPatchMem: writes incoming patches via port 0,
// reads them back in order via port 1 through a 2-entry output buffer.
module query_patch_mem_ctrl
  import qpm_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int PATCH_SIZE = PATCH_SIZE_D,
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int DEPTH      = DEPTH_D,
  localparam int PW        = DATA_WIDTH * PATCH_SIZE,
  localparam int CNT_W     = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_load,
  input  logic                  start_stream,
  input  logic [CNT_W-1:0]      cfg_num_patches,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PW-1:0]         in_patch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PW-1:0]         out_patch,
  output logic                  out_last,
  output logic                  load_done,
  output logic                  stream_done,
  output logic                  busy,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [PW-1:0]         mem_wpatch0,
  output logic                  mem_csb1,
  output logic [ADDR_WIDTH-1:0] mem_addr1,
  input  logic [PW-1:0]         mem_rpatch1
);

  state_e           state_r, state_nxt_s;
  logic [CNT_W-1:0] n_r, wr_cnt_r, rd_cnt_r, head_idx_r, cfg_n_s;
  logic             inflight_r, load_done_r, stream_done_r;
  logic             wr_s, last_wr_s, issue_s, pop_s, last_pop_s, start_s;
  logic [1:0]       fifo_count_s;
  logic [2:0]       occ_s;

  assign cfg_n_s = (cfg_num_patches > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : cfg_num_patches;
  assign start_s = (state_r == IDLE) && (start_load || start_stream);

  assign in_ready  = (state_r == LOAD);
  assign wr_s      = in_valid && in_ready;
  assign last_wr_s = wr_s && (wr_cnt_r == n_r - CNT_W'(1));

  // Buffer slots committed next cycle: held + returning read - leaving patch
  assign pop_s      = out_valid && out_ready;
  assign occ_s      = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign issue_s    = (state_r == STREAM) && (rd_cnt_r < n_r) && (occ_s < 3'd2);
  assign last_pop_s = pop_s && (head_idx_r == n_r - CNT_W'(1));

  assign out_valid   = (fifo_count_s != 2'd0);
  assign out_last    = out_valid && (head_idx_r == n_r - CNT_W'(1));
  assign load_done   = load_done_r;
  assign stream_done = stream_done_r;
  assign busy        = (state_r != IDLE);

  assign mem_csb0    = ~wr_s;
  assign mem_web0    = ~wr_s;
  assign mem_addr0   = wr_s ? wr_cnt_r[ADDR_WIDTH-1:0] : '0;
  assign mem_wpatch0 = wr_s ? in_patch : '0;
  assign mem_csb1    = ~issue_s;
  assign mem_addr1   = issue_s ? rd_cnt_r[ADDR_WIDTH-1:0] : '0;

  patch_fifo2 #(.W(PW)) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_r),
    .push_data (mem_rpatch1),
    .pop       (pop_s),
    .count     (fifo_count_s),
    .head      (out_patch)
  );

  // Next-state logic; an empty request stays in IDLE and only pulses done
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_load) begin
          state_nxt_s = (cfg_n_s != CNT_W'(0)) ? LOAD : IDLE;
        end else if (start_stream) begin
          state_nxt_s = (cfg_n_s != CNT_W'(0)) ? STREAM : IDLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (last_wr_s) state_nxt_s = IDLE;
        else           state_nxt_s = LOAD;
      end
      STREAM: begin
        if (last_pop_s) state_nxt_s = IDLE;
        else            state_nxt_s = STREAM;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and done pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      load_done_r   <= 1'b0;
      stream_done_r <= 1'b0;
      inflight_r    <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      load_done_r   <= last_wr_s ||
                       ((state_r == IDLE) && start_load && (cfg_n_s == CNT_W'(0)));
      stream_done_r <= last_pop_s ||
                       ((state_r == IDLE) && !start_load && start_stream && (cfg_n_s == CNT_W'(0)));
      inflight_r    <= issue_s;
    end
  end

  // Patch count latch and phase counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r        <= CNT_W'(0);
      wr_cnt_r   <= CNT_W'(0);
      rd_cnt_r   <= CNT_W'(0);
      head_idx_r <= CNT_W'(0);
    end else if (start_s) begin
      n_r        <= cfg_n_s;
      wr_cnt_r   <= CNT_W'(0);
      rd_cnt_r   <= CNT_W'(0);
      head_idx_r <= CNT_W'(0);
    end else begin
      if (wr_s)    wr_cnt_r   <= wr_cnt_r + CNT_W'(1);
      if (issue_s) rd_cnt_r   <= rd_cnt_r + CNT_W'(1);
      if (pop_s)   head_idx_r <= head_idx_r + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_query_patch_mem_ctrl.sv
// Directed bench for query_patch_mem_ctrl with a behavioural 1rw/1r memory model.
module tb_query_patch_mem_ctrl;

  localparam int PW = 55;
  localparam int AW = 9;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_load = 1'b0, start_stream = 1'b0;
  logic [CW-1:0] cfg_num_patches = '0;
  logic          in_valid = 1'b0, in_ready;
  logic [PW-1:0] in_patch = '0;
  logic          out_valid, out_ready = 1'b1, out_last;
  logic [PW-1:0] out_patch;
  logic          load_done, stream_done, busy;
  logic          mem_csb0, mem_web0, mem_csb1;
  logic [AW-1:0] mem_addr0, mem_addr1;
  logic [PW-1:0] mem_wpatch0;
  logic [PW-1:0] mem_rpatch1 = '0;
  logic [PW-1:0] mem [512];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Memory model: synchronous write on port 0, one-cycle read on port 1
  always @(posedge clk) begin
    if (!mem_csb0 && !mem_web0) mem[mem_addr0] <= mem_wpatch0;
    if (!mem_csb1) mem_rpatch1 <= mem[mem_addr1];
  end

  query_patch_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_load(start_load), .start_stream(start_stream),
    .cfg_num_patches(cfg_num_patches), .in_valid(in_valid), .in_ready(in_ready),
    .in_patch(in_patch), .out_valid(out_valid), .out_ready(out_ready),
    .out_patch(out_patch), .out_last(out_last), .load_done(load_done),
    .stream_done(stream_done), .busy(busy), .mem_csb0(mem_csb0), .mem_web0(mem_web0),
    .mem_addr0(mem_addr0), .mem_wpatch0(mem_wpatch0), .mem_csb1(mem_csb1),
    .mem_addr1(mem_addr1), .mem_rpatch1(mem_rpatch1)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if ({in_ready, out_valid, out_last, load_done, stream_done, busy} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 000000", {in_ready, out_valid, out_last, load_done, stream_done, busy});
    end
    n_chk++;
    if ({mem_csb0, mem_web0, mem_csb1} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_mem_ctrl got %b want 111", {mem_csb0, mem_web0, mem_csb1});
    end
    n_chk++;
    if (mem_addr0 !== 9'd0 || mem_addr1 !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_addr got %0d/%0d want 0/0", mem_addr0, mem_addr1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Loads patches 0xA..0xD; with both=1 also raises start_stream at start and mid-load
  task automatic load_four(input bit both);
    logic [PW-1:0] exp_p;
    @(negedge clk);
    cfg_num_patches = 10'd4; start_load = 1'b1; start_stream = both;
    #1;
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL load_idle_busy got %b want 0", busy); end
    @(negedge clk);
    start_load = 1'b0; start_stream = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_p = PW'(10 + i);
      in_valid = 1'b1; in_patch = exp_p;
      start_stream = both && (i == 1);
      #1;
      n_chk++;
      if ({in_ready, mem_csb0, mem_web0, mem_csb1} !== 4'b1001) begin
        n_fail++;
        $display("FAIL load_ctrl[%0d] got %b want 1001", i, {in_ready, mem_csb0, mem_web0, mem_csb1});
      end
      n_chk++;
      if (mem_addr0 !== AW'(i) || mem_wpatch0 !== exp_p) begin
        n_fail++;
        $display("FAIL load_write[%0d] got addr %0d data %h want addr %0d data %h", i, mem_addr0, mem_wpatch0, i, exp_p);
      end
      @(negedge clk);
    end
    start_stream = 1'b0; in_valid = 1'b1; in_patch = PW'(14);
    #1;
    n_chk++;
    if ({load_done, in_ready, mem_csb0, busy, mem_csb1} !== 5'b10101) begin
      n_fail++;
      $display("FAIL load_end got %b want 10101", {load_done, in_ready, mem_csb0, busy, mem_csb1});
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_chk++;
    if ({load_done, busy, mem_csb1} !== 3'b001) begin
      n_fail++;
      $display("FAIL load_after got %b want 001", {load_done, busy, mem_csb1});
    end
  endtask

  task automatic run_stream(input int n, input bit stall, output int first_rd, output int last_acc, output int done_cyc);
    int rd_exp, acc, issued;
    bit prev_stall;
    logic [PW-1:0] prev_patch;
    rd_exp = 0; acc = 0; issued = 0; prev_stall = 1'b0; prev_patch = '0;
    first_rd = -1; last_acc = -1; done_cyc = -1;
    @(negedge clk);
    cfg_num_patches = CW'(n); start_stream = 1'b1;
    @(negedge clk);
    start_stream = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (!mem_csb1) begin
        n_chk++;
        if (mem_addr1 !== AW'(rd_exp)) begin
          n_fail++; $display("FAIL stream_rd_addr got %0d want %0d", mem_addr1, rd_exp);
        end
        if (first_rd < 0) first_rd = cyc;
        rd_exp++; issued++;
      end
      if (prev_stall) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_patch !== prev_patch) begin
          n_fail++; $display("FAIL stream_stable got v=%b %h want v=1 %h", out_valid, out_patch, prev_patch);
        end
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (out_patch !== PW'(10 + acc)) begin
          n_fail++; $display("FAIL stream_patch[%0d] got %h want %h", acc, out_patch, PW'(10 + acc));
        end
        n_chk++;
        if (out_last !== (acc == n - 1)) begin
          n_fail++; $display("FAIL stream_last[%0d] got %b want %b", acc, out_last, (acc == n - 1));
        end
        acc++; last_acc = cyc;
      end
      n_chk++;
      if (issued - acc > 2) begin
        n_fail++; $display("FAIL stream_outstanding got %0d want <=2", issued - acc);
      end
      prev_stall = out_valid && !out_ready;
      prev_patch = out_patch;
      if (stream_done) begin done_cyc = cyc; break; end
      @(negedge clk);
    end
    out_ready = 1'b1;
    n_chk++;
    if (acc != n || done_cyc < 0) begin
      n_fail++; $display("FAIL stream_count got %0d accepted done_cyc %0d want %0d and done", acc, done_cyc, n);
    end
  endtask

  task automatic test_stream_full;
    int f, l, d;
    run_stream(4, 1'b0, f, l, d);
    n_chk++;
    if (f != 0 || l != 5 || d != 6) begin
      n_fail++; $display("FAIL stream_full_timing got rd %0d last %0d done %0d want 0 5 6", f, l, d);
    end
  endtask

  task automatic test_stream_stall;
    int f, l, d;
    run_stream(4, 1'b1, f, l, d);
    n_chk++;
    if (d != l + 1) begin
      n_fail++; $display("FAIL stream_stall_done got %0d want %0d", d, l + 1);
    end
  endtask

  task automatic test_zero_and_big;
    int writes;
    bit done;
    @(negedge clk);
    cfg_num_patches = 10'd0; start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    #1;
    n_chk++;
    if ({load_done, busy, mem_csb0} !== 3'b101) begin
      n_fail++; $display("FAIL zero_load got %b want 101", {load_done, busy, mem_csb0});
    end
    @(negedge clk);
    cfg_num_patches = 10'd600; start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    writes = 0; done = 1'b0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      in_valid = 1'b1; in_patch = PW'(cyc);
      #1;
      if (!mem_csb0 && !mem_web0) begin
        n_chk++;
        if (mem_addr0 !== AW'(writes)) begin
          n_fail++; $display("FAIL big_addr got %0d want %0d", mem_addr0, writes);
        end
        writes++;
      end
      if (load_done) begin done = 1'b1; break; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_chk++;
    if (writes != 512 || !done) begin
      n_fail++; $display("FAIL big_count got %0d writes done=%b want 512 done=1", writes, done);
    end
  endtask

  task automatic test_reset_mid_stream;
    int acc, f, l, d;
    bit seen;
    acc = 0; seen = 1'b0;
    @(negedge clk);
    cfg_num_patches = 10'd4; start_stream = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start_stream = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (out_valid && out_ready) acc++;
      if (acc == 2) break;
      @(negedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, mem_csb1, busy, stream_done} !== 4'b0100) begin
      n_fail++; $display("FAIL rst_mid got %b want 0100", {out_valid, mem_csb1, busy, stream_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stream_done || busy) seen = 1'b1;
      @(negedge clk);
    end
    n_chk++;
    if (seen) begin n_fail++; $display("FAIL rst_no_done got activity want none"); end
    run_stream(4, 1'b0, f, l, d);
    n_chk++;
    if (f != 0 || d != 6) begin
      n_fail++; $display("FAIL rst_restart got rd %0d done %0d want 0 6", f, d);
    end
  endtask

  initial begin
    test_reset();
    load_four(1'b0);
    test_stream_full();
    test_stream_stall();
    test_zero_and_big();
    load_four(1'b1);
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
